// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder and its store queue.
package dmem_pkg;

    localparam int unsigned WORD_W    = 64;
    // Widest supported word index; DEPTH_WORDS must not exceed 2**IDX_MAX_W.
    localparam int unsigned IDX_MAX_W = 16;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [IDX_MAX_W-1:0] idx_t;

    typedef struct packed {
        idx_t  index;
        word_t data;
    } sq_entry_t;

    typedef enum logic [1:0] {
        SQ_EMPTY   = 2'd0,
        SQ_PARTIAL = 2'd1,
        SQ_FULL    = 2'd2
    } sq_state_e;

endpackage

// File: rtl/dmem_store_queue.sv
// Circular store queue with occupancy state and youngest-match lookup.
module dmem_store_queue
    import dmem_pkg::*;
#(
    parameter int unsigned SQ_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      enq,
    input  sq_entry_t enq_entry,
    input  logic      deq,
    input  idx_t      lookup_idx,
    output sq_entry_t head_entry,
    output sq_state_e state,
    output logic      hit,
    output word_t     hit_data
);

    localparam int unsigned PTR_W = $clog2(SQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sq_entry_t        entries [SQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_enq;
    logic             do_deq;

    assign do_enq     = enq && (state != SQ_FULL);
    assign do_deq     = deq && (state != SQ_EMPTY);
    assign head_entry = entries[head];

    // Simultaneous enqueue and dequeue leave the occupancy unchanged.
    always_comb begin
        count_nxt = count;
        if (do_enq && !do_deq) begin
            count_nxt = count + CNT_W'(1);
        end else if (do_deq && !do_enq) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= SQ_EMPTY;
        end else begin
            if (do_enq) tail <= tail + PTR_W'(1);
            if (do_deq) head <= head + PTR_W'(1);
            count <= count_nxt;
            if (count_nxt == '0) begin
                state <= SQ_EMPTY;
            end else if (count_nxt == CNT_W'(SQ_DEPTH)) begin
                state <= SQ_FULL;
            end else begin
                state <= SQ_PARTIAL;
            end
        end
    end

    // Slot storage is not reset: a zero count already marks every slot stale.
    always_ff @(posedge clk) begin
        if (do_enq) entries[tail] <= enq_entry;
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (entries[head + PTR_W'(i)].index == lookup_idx)) begin
                hit      = 1'b1;
                hit_data = entries[head + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array, store queue drain arbitration, 1-cycle load port.
// Define DMEM_FWD_EN to enable store-to-load forwarding from the store queue.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned SQ_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] dmem_addressLoad,
    input  logic [63:0] dmem_addressStore,
    input  logic [63:0] dmem_WriteData,
    input  logic        dmem_readEn,
    input  logic        dmem_writeEn,
    output logic [63:0] dmem_readData,
    output logic        stall_o,
    output logic        overflow_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    word_t            mem [DEPTH_WORDS];
    logic [IDX_W-1:0] ld_idx;
    logic [IDX_W-1:0] st_idx;
    sq_entry_t        st_entry;
    sq_entry_t        head_entry;
    sq_state_e        sq_state;
    logic             enq;
    logic             drain;
    logic             fwd_hit;
    word_t            fwd_data;
    logic             unused_bits;

    assign ld_idx   = dmem_addressLoad[IDX_W+2:3];
    assign st_idx   = dmem_addressStore[IDX_W+2:3];
    assign st_entry = '{index: IDX_MAX_W'(st_idx), data: dmem_WriteData};

`ifdef DMEM_FWD_EN
    assign stall_o     = (sq_state == SQ_FULL);
    assign unused_bits = ^{dmem_addressLoad, dmem_addressStore, head_entry.index};
`else
    // Without forwarding the queue must be empty before a load may be trusted.
    assign stall_o     = (sq_state != SQ_EMPTY);
    assign unused_bits = ^{dmem_addressLoad, dmem_addressStore, head_entry.index,
                           fwd_hit, fwd_data};
`endif

    // A load owns the array port; the queue drains only on load-free cycles.
    assign enq   = reset && dmem_writeEn && !stall_o;
    assign drain = reset && !dmem_readEn && (sq_state != SQ_EMPTY);

    dmem_store_queue #(
        .SQ_DEPTH (SQ_DEPTH)
    ) u_store_queue (
        .clk        (clk),
        .reset      (reset),
        .enq        (enq),
        .enq_entry  (st_entry),
        .deq        (drain),
        .lookup_idx (IDX_MAX_W'(ld_idx)),
        .head_entry (head_entry),
        .state      (sq_state),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
    );

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (drain) mem[head_entry.index[IDX_W-1:0]] <= head_entry.data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dmem_readData <= '0;
            overflow_o    <= 1'b0;
        end else begin
            if (dmem_readEn) begin
`ifdef DMEM_FWD_EN
                dmem_readData <= fwd_hit ? fwd_data : mem[ld_idx];
`else
                dmem_readData <= mem[ld_idx];
`endif
            end
            if (dmem_writeEn && stall_o) overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH_WORDS = 128;
    localparam int unsigned SQ_DEPTH    = 4;
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] dmem_addressLoad;
    logic [63:0] dmem_addressStore;
    logic [63:0] dmem_WriteData;
    logic        dmem_readEn;
    logic        dmem_writeEn;
    logic [63:0] dmem_readData;
    logic        stall_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned idx;
        logic [63:0] data;
    } st_t;

    st_t         sq [$];
    logic [63:0] mmem [DEPTH_WORDS];
    logic [63:0] exp_rd;
    logic        exp_ovf;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .SQ_DEPTH    (SQ_DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .dmem_addressLoad  (dmem_addressLoad),
        .dmem_addressStore (dmem_addressStore),
        .dmem_WriteData    (dmem_WriteData),
        .dmem_readEn       (dmem_readEn),
        .dmem_writeEn      (dmem_writeEn),
        .dmem_readData     (dmem_readData),
        .stall_o           (stall_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic int unsigned aidx(input logic [63:0] a);
        return 32'(a[IDX_W+2:3]);
    endfunction

    function automatic logic [63:0] mk_addr(input int unsigned idx);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[IDX_W+2:3] = IDX_W'(idx);
        return a;
    endfunction

    function automatic logic model_stall();
`ifdef DMEM_FWD_EN
        return sq.size() == int'(SQ_DEPTH);
`else
        return sq.size() != 0;
`endif
    endfunction

    function automatic logic [63:0] model_load(input int unsigned idx);
`ifdef DMEM_FWD_EN
        for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].idx == idx) return sq[i].data;
        end
`endif
        return mmem[idx];
    endfunction

    // Drive one cycle (called at negedge), advance the model, return at next negedge.
    task automatic step(input logic rst, input logic re, input logic we,
                        input logic [63:0] la, input logic [63:0] sa, input logic [63:0] wd);
        logic stl;
        st_t  e;
        reset             = rst;
        dmem_readEn       = re;
        dmem_writeEn      = we;
        dmem_addressLoad  = la;
        dmem_addressStore = sa;
        dmem_WriteData    = wd;
        if (!rst) begin
            sq.delete();
            exp_rd  = '0;
            exp_ovf = 1'b0;
        end else begin
            stl = model_stall();
            if (re) exp_rd = model_load(aidx(la));
            if (we && stl) exp_ovf = 1'b1;
            if (!re && sq.size() != 0) begin
                mmem[sq[0].idx] = sq[0].data;
                void'(sq.pop_front());
            end
            if (we && !stl) begin
                e.idx  = aidx(sa);
                e.data = wd;
                sq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic st(input logic [63:0] a, input logic [63:0] d);
        step(1'b1, 1'b0, 1'b1, '0, a, d);
    endtask

    task automatic ld(input logic [63:0] a);
        step(1'b1, 1'b1, 1'b0, a, '0, '0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, mk_addr(3), mk_addr(3), {$urandom, $urandom});
        step(1'b0, 1'b1, 1'b1, mk_addr(4), mk_addr(4), {$urandom, $urandom});
        checks++;
        if (dmem_readData !== 64'h0) begin
            failures++;
            $display("FAIL reset_readData: got %h expected %h", dmem_readData, 64'h0);
        end
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow: got %b expected 0", overflow_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b expected 0", stall_o);
        end
    endtask

    task automatic preload();
        for (int unsigned i = 0; i < 64; i++) begin
            st(mk_addr(i), {$urandom, $urandom});
            idle();
        end
    endtask

    task automatic test_basic();
        st(64'h40, 64'h1122334455667788);
        idle();
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_drained_stall: got %b expected 0", stall_o);
        end
        ld(64'h40);
        checks++;
        if (dmem_readData !== 64'h1122334455667788) begin
            failures++;
            $display("FAIL basic_load: got %h expected %h", dmem_readData, 64'h1122334455667788);
        end
        idle();
        idle();
        checks++;
        if (dmem_readData !== 64'h1122334455667788) begin
            failures++;
            $display("FAIL basic_hold: got %h expected %h", dmem_readData, 64'h1122334455667788);
        end
    endtask

    task automatic test_forward();
`ifdef DMEM_FWD_EN
        st(64'h80, 64'hA);
        st(64'h80, 64'hB);
        ld(64'h80);
        checks++;
        if (dmem_readData !== 64'hB) begin
            failures++;
            $display("FAIL fwd_youngest: got %h expected %h", dmem_readData, 64'hB);
        end
        idle();
        ld(64'h80);
        checks++;
        if (dmem_readData !== 64'hB) begin
            failures++;
            $display("FAIL fwd_after_drain: got %h expected %h", dmem_readData, 64'hB);
        end
`else
        st(64'h80, 64'hA);
        checks++;
        if (stall_o !== 1'b1) begin
            failures++;
            $display("FAIL nofwd_stall: got %b expected 1", stall_o);
        end
        st(64'h80, 64'hB);
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL nofwd_drop: got %b expected 1", overflow_o);
        end
        ld(64'h80);
        checks++;
        if (dmem_readData !== 64'hA) begin
            failures++;
            $display("FAIL nofwd_load: got %h expected %h", dmem_readData, 64'hA);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL nofwd_ovf_clear: got %b expected 0", overflow_o);
        end
`endif
    endtask

    task automatic test_full();
        logic exp_s;
        for (int unsigned k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b1, mk_addr(0), mk_addr(20 + k), {$urandom, $urandom});
            exp_s = 1'b1;
`ifdef DMEM_FWD_EN
            exp_s = (k >= 3);
`endif
            checks++;
            if (stall_o !== exp_s) begin
                failures++;
                $display("FAIL full_stall k=%0d: got %b expected %b", k, stall_o, exp_s);
            end
        end
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL full_overflow: got %b expected 1", overflow_o);
        end
        for (int unsigned j = 0; j < 4; j++) idle();
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL full_drained_stall: got %b expected 0", stall_o);
        end
        for (int unsigned k = 0; k < 5; k++) begin
            ld(mk_addr(20 + k));
            checks++;
            if (dmem_readData !== exp_rd) begin
                failures++;
                $display("FAIL full_load k=%0d: got %h expected %h", k, dmem_readData, exp_rd);
            end
        end
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_same_cycle();
        st(64'h100, 64'h5);
        idle();
        step(1'b1, 1'b1, 1'b1, 64'h100, 64'h100, 64'hCAFE_F00D_1234_5678);
        checks++;
        if (dmem_readData !== 64'h5) begin
            failures++;
            $display("FAIL same_cycle_old: got %h expected %h", dmem_readData, 64'h5);
        end
`ifndef DMEM_FWD_EN
        idle();
`endif
        ld(64'h100);
        checks++;
        if (dmem_readData !== 64'hCAFE_F00D_1234_5678) begin
            failures++;
            $display("FAIL same_cycle_new: got %h expected %h", dmem_readData, 64'hCAFE_F00D_1234_5678);
        end
    endtask

    task automatic test_reset_mid();
        for (int unsigned k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1, mk_addr(0), mk_addr(40 + k), {$urandom, $urandom});
        end
        step(1'b0, 1'b0, 1'b1, '0, mk_addr(43), {$urandom, $urandom});
        checks++;
        if (dmem_readData !== 64'h0) begin
            failures++;
            $display("FAIL rstmid_readData: got %h expected %h", dmem_readData, 64'h0);
        end
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_overflow: got %b expected 0", overflow_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_stall: got %b expected 0", stall_o);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            ld(mk_addr(40 + k));
            checks++;
            if (dmem_readData !== exp_rd) begin
                failures++;
                $display("FAIL rstmid_prior k=%0d: got %h expected %h", k, dmem_readData, exp_rd);
            end
        end
    endtask

    task automatic test_alias();
        st(64'h47, 64'h0123_4567_89AB_CDEF);
        idle();
        ld(64'h40);
        checks++;
        if (dmem_readData !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL alias_low_bits: got %h expected %h", dmem_readData, 64'h0123_4567_89AB_CDEF);
        end
        st(64'(DEPTH_WORDS * 8), 64'hDEAD_BEEF_0000_0001);
        idle();
        ld(64'h0);
        checks++;
        if (dmem_readData !== 64'hDEAD_BEEF_0000_0001) begin
            failures++;
            $display("FAIL alias_wrap: got %h expected %h", dmem_readData, 64'hDEAD_BEEF_0000_0001);
        end
        ld(64'hFFFF_0000_0000_0005);
        checks++;
        if (dmem_readData !== 64'hDEAD_BEEF_0000_0001) begin
            failures++;
            $display("FAIL alias_upper_bits: got %h expected %h", dmem_readData, 64'hDEAD_BEEF_0000_0001);
        end
    endtask

    task automatic test_random();
        logic rst;
        logic re;
        logic we;
        for (int unsigned n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            re  = 1'($urandom_range(0, 1));
            we  = model_stall() ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
            step(rst, re, we, mk_addr($urandom_range(0, 15)), mk_addr($urandom_range(0, 15)),
                 {$urandom, $urandom});
            checks++;
            if (dmem_readData !== exp_rd) begin
                failures++;
                $display("FAIL rand_readData n=%0d: got %h expected %h", n, dmem_readData, exp_rd);
            end
            checks++;
            if (overflow_o !== exp_ovf) begin
                failures++;
                $display("FAIL rand_overflow n=%0d: got %b expected %b", n, overflow_o, exp_ovf);
            end
            checks++;
            if (stall_o !== model_stall()) begin
                failures++;
                $display("FAIL rand_stall n=%0d: got %b expected %b", n, stall_o, model_stall());
            end
        end
    endtask

    initial begin
        reset             = 1'b0;
        dmem_readEn       = 1'b0;
        dmem_writeEn      = 1'b0;
        dmem_addressLoad  = '0;
        dmem_addressStore = '0;
        dmem_WriteData    = '0;
        exp_rd            = '0;
        exp_ovf           = 1'b0;
        test_reset();
        preload();
        test_basic();
        test_forward();
        test_full();
        test_same_cycle();
        test_reset_mid();
        test_alias();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
